// File: rtl/bk_pkg.sv
// rtl/bk_pkg.sv - shared types and helpers for the Brent-Kung frame accumulator
package bk_pkg;

  localparam int BK_W     = 12;
  localparam int BK_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Adder operand bus: a on even bits, b on odd bits.
  function automatic logic [2*BK_W-1:0] interleave(input logic [BK_W-1:0] a,
                                                   input logic [BK_W-1:0] b);
    logic [2*BK_W-1:0] bus;
    for (int i = 0; i < BK_W; i++) begin
      bus[2*i]   = a[i];
      bus[2*i+1] = b[i];
    end
    return bus;
  endfunction

endpackage

// File: rtl/bk_accumulator_adder.sv
// rtl/bk_accumulator_adder.sv - combinational 12-bit Brent-Kung adder on an interleaved operand bus
module BrentKung (
  input  logic [23:0] INPUTS,
  output logic [12:0] OUTS
);

  localparam int N = 12;

  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] p0;
  logic [N-1:0] carry;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a[i] = INPUTS[2*i];
      b[i] = INPUTS[2*i+1];
    end
    g  = a & b;
    p  = a ^ b;
    p0 = p;
    // Up-sweep: nodes at (i+1) multiple of 2d absorb the block d below them.
    for (int d = 1; d < N; d = d * 2) begin
      for (int i = 0; i < N; i++) begin
        if ((i + 1) % (2 * d) == 0) begin
          g[i] = g[i] | (p[i] & g[i-d]);
          p[i] = p[i] & p[i-d];
        end
      end
    end
    // Down-sweep fills the remaining prefixes from completed ones.
    for (int d = 4; d >= 1; d = d / 2) begin
      for (int i = 0; i < N; i++) begin
        if (((i + 1) % (2 * d) == d) && (i >= 2 * d)) begin
          g[i] = g[i] | (p[i] & g[i-d]);
          p[i] = p[i] & p[i-d];
        end
      end
    end
    carry = {g[N-2:0], 1'b0};
    OUTS  = {g[N-1], p0 ^ carry};
  end

endmodule

// File: rtl/bk_accumulator.sv
// rtl/bk_accumulator.sv - saturating frame accumulator feeding a Brent-Kung adder
module bk_accumulator
  import bk_pkg::*;
#(
  parameter int CNT_W = BK_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BK_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BK_W-1:0]  out_sum,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  localparam int W = BK_W;

  state_t           state;
  logic [W-1:0]     acc;
  logic             sat;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_r;
  logic             out_valid_r;

  logic [2*W-1:0]   operands;
  logic [W:0]       outs;
  logic             accept;
  logic [CNT_W-1:0] cfg_eff;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_next;
  logic             last;

  assign operands = interleave(acc, in_data);

  BrentKung u_adder (
    .INPUTS (operands),
    .OUTS   (outs)
  );

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;
  assign cfg_eff  = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
  // The first beat of a frame must compare against the live config, not len_r.
  assign len_eff  = (state == IDLE) ? cfg_eff : len_r;
  assign cnt_next = cnt + CNT_W'(1);
  assign last     = (cnt_next == len_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      sat         <= 1'b0;
      cnt         <= '0;
      len_r       <= CNT_W'(1);
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= outs[W] ? {W{1'b1}} : outs[W-1:0];
            sat <= sat | outs[W];
            cnt <= cnt_next;
            if (state == IDLE) begin
              len_r <= cfg_eff;
            end
            if (last) begin
              state       <= HOLD;
              out_valid_r <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            acc         <= '0;
            sat         <= 1'b0;
            cnt         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_sum   = acc;
  assign out_sat   = sat;
  assign out_count = cnt;

endmodule

// File: tb/tb_bk_accumulator.sv
// tb/tb_bk_accumulator.sv - randomized self-checking bench for bk_accumulator
module tb_bk_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_len = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_sum;
  logic        out_sat;
  logic [7:0]  out_count;

  bk_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [11:0] smp [0:15];

  logic [11:0] got_sum;
  logic        got_sat;
  logic        got_valid;
  logic [7:0]  got_count;
  logic        got_early;
  logic        got_after_ready;
  logic        got_after_valid;

  int          exp_sum;
  logic        exp_sat;

  // Reference: running total clamped to 4095 after each sample.
  task automatic model(input int n);
    int total;
    total   = 0;
    exp_sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      total = total + int'(smp[i]);
      if (total > 4095) begin
        total   = 4095;
        exp_sat = 1'b1;
      end
    end
    exp_sum = total;
  endtask

  task automatic run_frame(input logic [7:0] len, input int n);
    got_early = 1'b0;
    cfg_len   = len;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) got_early = 1'b1;
      in_valid = 1'b1;
      in_data  = smp[i];
      @(posedge clk);
      #1;
      cfg_len = 8'($urandom);
    end
    in_valid = 1'b0;
    @(negedge clk);
    got_valid = out_valid;
    got_sum   = out_sum;
    got_sat   = out_sat;
    got_count = out_count;
  endtask

  task automatic finish_frame();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    got_after_ready = in_ready;
    got_after_valid = out_valid;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_sat, out_count} !== {1'b1, 1'b0, 12'd0, 1'b0, 8'd0})
      $display("FAIL reset_values got rdy=%0b vld=%0b sum=%0d sat=%0b cnt=%0d want 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_sat, out_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    smp[0] = 12'd100; smp[1] = 12'd200; smp[2] = 12'd300;
    run_frame(8'd3, 3);
    n_checks++;
    if (got_valid !== 1'b1 || got_early !== 1'b0)
      $display("FAIL basic_latency got valid=%0b early=%0b want 1 0", got_valid, got_early);
    else n_pass++;
    n_checks++;
    if ({got_sum, got_sat, got_count} !== {12'd600, 1'b0, 8'd3})
      $display("FAIL basic_result got sum=%0d sat=%0b cnt=%0d want 600 0 3", got_sum, got_sat, got_count);
    else n_pass++;
    finish_frame();
    n_checks++;
    if (got_after_ready !== 1'b1 || got_after_valid !== 1'b0)
      $display("FAIL basic_release got rdy=%0b vld=%0b want 1 0", got_after_ready, got_after_valid);
    else n_pass++;
  endtask

  task automatic test_saturation();
    smp[0] = 12'd4000; smp[1] = 12'd200;
    run_frame(8'd2, 2);
    n_checks++;
    if ({got_valid, got_sum, got_sat, got_count} !== {1'b1, 12'd4095, 1'b1, 8'd2})
      $display("FAIL sat_frame got vld=%0b sum=%0d sat=%0b cnt=%0d want 1 4095 1 2",
               got_valid, got_sum, got_sat, got_count);
    else n_pass++;
    finish_frame();
    smp[0] = 12'd4095; smp[1] = 12'd0; smp[2] = 12'd0;
    run_frame(8'd3, 3);
    n_checks++;
    if ({got_valid, got_sum, got_sat, got_count} !== {1'b1, 12'd4095, 1'b0, 8'd3})
      $display("FAIL full_plus_zero got vld=%0b sum=%0d sat=%0b cnt=%0d want 1 4095 0 3",
               got_valid, got_sum, got_sat, got_count);
    else n_pass++;
    finish_frame();
  endtask

  task automatic test_interleave();
    smp[0] = 12'h555; smp[1] = 12'hAAA;
    run_frame(8'd2, 2);
    n_checks++;
    if ({got_sum, got_sat} !== {12'hFFF, 1'b0})
      $display("FAIL interleave_alt got sum=%0h sat=%0b want fff 0", got_sum, got_sat);
    else n_pass++;
    finish_frame();
    smp[0] = 12'h001; smp[1] = 12'hFFF;
    run_frame(8'd2, 2);
    n_checks++;
    if ({got_sum, got_sat} !== {12'hFFF, 1'b1})
      $display("FAIL interleave_carry got sum=%0h sat=%0b want fff 1", got_sum, got_sat);
    else n_pass++;
    finish_frame();
  endtask

  task automatic test_len_zero();
    smp[0] = 12'd7;
    run_frame(8'd0, 1);
    n_checks++;
    if ({got_valid, got_sum, got_sat, got_count} !== {1'b1, 12'd7, 1'b0, 8'd1})
      $display("FAIL len_zero got vld=%0b sum=%0d sat=%0b cnt=%0d want 1 7 0 1",
               got_valid, got_sum, got_sat, got_count);
    else n_pass++;
    finish_frame();
  endtask

  task automatic test_backpressure();
    smp[0] = 12'($urandom_range(0, 2000));
    smp[1] = 12'($urandom_range(0, 2000));
    model(2);
    run_frame(8'd2, 2);
    in_valid = 1'b1;
    in_data  = 12'hABC;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, out_sum, out_count} !== {1'b1, 1'b0, 12'(exp_sum), 8'd2})
        $display("FAIL backpressure_hold cyc=%0d got vld=%0b rdy=%0b sum=%0d cnt=%0d want 1 0 %0d 2",
                 c, out_valid, in_ready, out_sum, out_count, exp_sum);
      else n_pass++;
    end
    in_valid = 1'b0;
    finish_frame();
    n_checks++;
    if (got_after_ready !== 1'b1 || got_after_valid !== 1'b0)
      $display("FAIL backpressure_release got rdy=%0b vld=%0b want 1 0", got_after_ready, got_after_valid);
    else n_pass++;
    smp[0] = 12'd9;
    run_frame(8'd1, 1);
    n_checks++;
    if ({got_sum, got_count} !== {12'd9, 8'd1})
      $display("FAIL backpressure_noconsume got sum=%0d cnt=%0d want 9 1", got_sum, got_count);
    else n_pass++;
    finish_frame();
  endtask

  task automatic test_reset_midframe();
    cfg_len = 8'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 12'd50 + 12'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_sat, out_count} !== {1'b1, 1'b0, 12'd0, 1'b0, 8'd0})
      $display("FAIL midframe_reset got rdy=%0b vld=%0b sum=%0d sat=%0b cnt=%0d want 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_sat, out_count);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    smp[0] = 12'd5;
    run_frame(8'd1, 1);
    n_checks++;
    if ({got_valid, got_sum, got_count} !== {1'b1, 12'd5, 8'd1})
      $display("FAIL after_reset_frame got vld=%0b sum=%0d cnt=%0d want 1 5 1", got_valid, got_sum, got_count);
    else n_pass++;
    finish_frame();
  endtask

  task automatic test_random();
    int          len;
    int          eff;
    int          stall;
    logic        big;
    for (int f = 0; f < 25; f++) begin
      len   = $urandom_range(0, 7);
      eff   = (len == 0) ? 1 : len;
      big   = 1'($urandom);
      stall = $urandom_range(0, 3);
      for (int i = 0; i < eff; i++)
        smp[i] = big ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 400));
      model(eff);
      run_frame(8'(len), eff);
      n_checks++;
      if ({got_valid, got_early, got_sum, got_sat, got_count} !== {1'b1, 1'b0, 12'(exp_sum), exp_sat, 8'(eff)})
        $display("FAIL random_frame f=%0d got vld=%0b early=%0b sum=%0d sat=%0b cnt=%0d want 1 0 %0d %0b %0d",
                 f, got_valid, got_early, got_sum, got_sat, got_count, exp_sum, exp_sat, eff);
      else n_pass++;
      in_valid = 1'($urandom);
      in_data  = 12'($urandom);
      for (int c = 0; c < stall; c++) begin
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, out_sum, out_sat} !== {1'b1, 1'b0, 12'(exp_sum), exp_sat})
          $display("FAIL random_stall f=%0d got vld=%0b rdy=%0b sum=%0d sat=%0b want 1 0 %0d %0b",
                   f, out_valid, in_ready, out_sum, out_sat, exp_sum, exp_sat);
        else n_pass++;
      end
      in_valid = 1'b0;
      finish_frame();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_interleave();
    test_len_zero();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
